main_fsm: RTL and testbench
===========================

// Module: main_fsm
// PURPOSE
//  Moore main state machine of the multicycle ARM controller. Sequences each instruction through
//  fetch/decode/execute/writeback, driving datapath mux selects and write strobes. Sits between
//  the instruction decode (Op/Funct) and the conditional-logic/ALU-decoder stages of the controller.
// PARAMETERS
//  CNT_W   32  width of performance counters (used only when MAIN_FSM_PERF_EN is defined)
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  reset        in   1  synchronous, active-low
//  op           in   2  Instr[27:26]
//  funct        in   6  Instr[25:20]
//  irwrite      out  1  instruction register load strobe
//  adrsrc       out  1  memory address select: 0=PC, 1=ALUOut
//  alusrca      out  2  00=register A, 01=PC; 10/11 never driven
//  alusrcb      out  2  00=register B, 01=ExtImm, 10=constant 4
//  resultsrc    out  2  00=ALUOut, 01=Data, 10=ALUResult
//  nextpc       out  1  PC update request (fetch)
//  regw         out  1  register-file write request (pre-condition)
//  memw         out  1  memory write request (pre-condition)
//  branch       out  1  branch request (pre-condition)
//  aluop        out  1  1=ALU decoder uses funct; 0=force ADD
//  state_o      out  4  current state encoding (debug)
//  cycle_cnt    out  CNT_W  clock cycles since reset   (MAIN_FSM_PERF_EN only)
//  instr_cnt    out  CNT_W  instructions retired       (MAIN_FSM_PERF_EN only)
// BEHAVIOUR
//  - States/encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECUTER=6
//    EXECUTEI=7 ALUWB=8 BRANCH=9 UNKNOWN=10; codes 11-15 illegal.
//  - Reset: rising clk with reset==0 -> state=FETCH. While reset==0, irwrite/nextpc/regw/memw/branch
//    forced 0 combinationally; selects show FETCH values; state_o=0. First FETCH strobes assert in
//    the first cycle after reset returns to 1. Reset mid-instruction aborts it (no retire count).
//  - Transitions (one per clock): FETCH->DECODE. DECODE: op=01->MEMADR; op=00&funct[5]=0->EXECUTER;
//    op=00&funct[5]=1->EXECUTEI; op=10->BRANCH; op=11->UNKNOWN. MEMADR: funct[0]=1->MEMREAD else
//    MEMWRITE. MEMREAD->MEMWB. EXECUTER/EXECUTEI->ALUWB. MEMWB, MEMWRITE, ALUWB, BRANCH,
//    UNKNOWN, illegal codes -> FETCH.
//  - op/funct sampled only in DECODE and MEMADR; ignored elsewhere.
//  - Outputs (unlisted = 0; selects unlisted = 00):
//    FETCH: irwrite=1 nextpc=1 adrsrc=0 alusrca=01 alusrcb=10 resultsrc=10 aluop=0
//    DECODE: alusrca=01 alusrcb=10 resultsrc=10
//    MEMADR: alusrca=00 alusrcb=01
//    MEMREAD: adrsrc=1 resultsrc=00      MEMWB: resultsrc=01 regw=1
//    MEMWRITE: adrsrc=1 memw=1           EXECUTER: alusrcb=00 aluop=1
//    EXECUTEI: alusrcb=01 aluop=1         ALUWB: resultsrc=00 regw=1
//    BRANCH: alusrca=00 alusrcb=01 resultsrc=10 branch=1
//    UNKNOWN/illegal: all outputs 0 (no strobes).
//  - Latency (cycles incl. FETCH): LDR 5, STR 4, DP-reg 4, DP-imm 4, B 3, undefined op 3.
//  - Outputs purely f(state) (Moore) apart from reset gating; no input-to-output combinational path.
// CONFIGURATION
//  - MAIN_FSM_PERF_EN defined: cycle_cnt and instr_cnt ports present. Both cleared to 0 in reset.
//    cycle_cnt +1 every clock with reset==1. instr_cnt +1 on each clock leaving MEMWB, MEMWRITE,
//    ALUWB or BRANCH (UNKNOWN not counted). Both wrap modulo 2^CNT_W, no saturation/flag.
//  - Not defined: ports and counter logic absent; FSM behaviour identical.
// TESTING
//  - reset=0 two cycles, release -> state_o 0,1 on successive cycles; irwrite=nextpc=1 only in cycle 1
//    after release; strobes 0 throughout reset.
//  - LDR: op=01 funct=011001 -> state_o 0,1,2,3,4,0; regw=1 only in state 4 with resultsrc=01.
//  - STR: op=01 funct=011000 -> 0,1,2,5,0; memw=1 and adrsrc=1 in state 5 only; regw never 1.
//  - DP: op=00 funct=101000 -> 0,1,7,8,0 (alusrcb=01,aluop=1 in 7); funct=001000 -> 0,1,6,8,0.
//  - B: op=10 -> 0,1,9,0 with branch=1, alusrcb=01 in 9; op=11 -> 0,1,10,0, all outputs 0 in 10.
//  - PERF (CNT_W=4): 20 instrs mixed -> instr_cnt=4 (wrap from 20); reset asserted in MEMREAD ->
//    next cycle state_o=0, both counters 0.

Source files
------------

// File: rtl/main_fsm_if.sv
// ----------------------------------------------------------------------------
// main_fsm_if
//   Bundles the instruction-field inputs and the datapath control outputs of
//   the multicycle ARM main FSM.
//
//   master : controller side (main_fsm). Consumes op/funct and drives the
//            datapath selects and the write/branch request strobes.
//   slave  : datapath/downstream side. Drives op/funct, observes the controls.
//
//   Signals
//     op[1:0]         Instr[27:26]
//     funct[5:0]      Instr[25:20]
//     irwrite         instruction register load strobe
//     adrsrc          memory address select: 0=PC, 1=ALUOut
//     alusrca[1:0]    00=register A, 01=PC
//     alusrcb[1:0]    00=register B, 01=ExtImm, 10=constant 4
//     resultsrc[1:0]  00=ALUOut, 01=Data, 10=ALUResult
//     nextpc          PC update request
//     regw            register-file write request (before condition check)
//     memw            memory write request (before condition check)
//     branch          branch request (before condition check)
//     aluop           1=ALU decoder uses funct, 0=force ADD
//
//   There is no valid/ready handshake on this bundle: the controls are
//   level signals that are meaningful every cycle, and op/funct are expected
//   to be stable whenever the FSM is in DECODE or MEMADR.
// ----------------------------------------------------------------------------
interface main_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;

    modport master (
        input  op, funct,
        output irwrite, adrsrc, alusrca, alusrcb, resultsrc,
               nextpc, regw, memw, branch, aluop
    );

    modport slave (
        output op, funct,
        input  irwrite, adrsrc, alusrca, alusrcb, resultsrc,
               nextpc, regw, memw, branch, aluop
    );
endinterface

// File: rtl/main_fsm.sv
// ----------------------------------------------------------------------------
// main_fsm
//   Moore main state machine of the multicycle ARM controller. Steps each
//   instruction through fetch / decode / execute / writeback and drives the
//   datapath mux selects and write request strobes. Outputs depend only on
//   the current state, except that an asserted reset gates them.
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     reset      synchronous, active-low
//     bus        main_fsm_if.master: op/funct in, datapath controls out
//     cycle_cnt  clock cycles since reset     (MAIN_FSM_PERF_EN only)
//     instr_cnt  instructions retired         (MAIN_FSM_PERF_EN only)
//     state_o    current state encoding (debug), 0 while in reset
//
//   Optional feature
//     MAIN_FSM_PERF_EN : when defined, adds parameter CNT_W (default 32) and
//     the two wrapping performance counters above.
// ----------------------------------------------------------------------------
module main_fsm
`ifdef MAIN_FSM_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    main_fsm_if.master       bus,
`ifdef MAIN_FSM_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    state_t state;
    state_t state_next;

    logic       irwrite_s;
    logic       adrsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] resultsrc_s;
    logic       nextpc_s;
    logic       regw_s;
    logic       memw_s;
    logic       branch_s;
    logic       aluop_s;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; op/funct only matter in DECODE and MEMADR.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    2'b00:   state_next = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_next = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            // MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN and the unused codes
            // all return to FETCH.
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs. While reset is low the strobes are forced off and the
    // selects show FETCH values so the datapath sits in a known fetch setup.
    always_comb begin
        irwrite_s   = 1'b0;
        adrsrc_s    = 1'b0;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        resultsrc_s = 2'b00;
        nextpc_s    = 1'b0;
        regw_s      = 1'b0;
        memw_s      = 1'b0;
        branch_s    = 1'b0;
        aluop_s     = 1'b0;

        if (!reset) begin
            alusrca_s   = 2'b01;
            alusrcb_s   = 2'b10;
            resultsrc_s = 2'b10;
        end else begin
            case (state)
                S_FETCH: begin
                    irwrite_s   = 1'b1;
                    nextpc_s    = 1'b1;
                    alusrca_s   = 2'b01;
                    alusrcb_s   = 2'b10;
                    resultsrc_s = 2'b10;
                end
                S_DECODE: begin
                    alusrca_s   = 2'b01;
                    alusrcb_s   = 2'b10;
                    resultsrc_s = 2'b10;
                end
                S_MEMADR: begin
                    alusrcb_s   = 2'b01;
                end
                S_MEMREAD: begin
                    adrsrc_s    = 1'b1;
                end
                S_MEMWB: begin
                    resultsrc_s = 2'b01;
                    regw_s      = 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc_s    = 1'b1;
                    memw_s      = 1'b1;
                end
                S_EXECUTER: begin
                    aluop_s     = 1'b1;
                end
                S_EXECUTEI: begin
                    alusrcb_s   = 2'b01;
                    aluop_s     = 1'b1;
                end
                S_ALUWB: begin
                    regw_s      = 1'b1;
                end
                S_BRANCH: begin
                    alusrcb_s   = 2'b01;
                    resultsrc_s = 2'b10;
                    branch_s    = 1'b1;
                end
                // UNKNOWN and unused codes: everything stays 0.
                default: ;
            endcase
        end
    end

    assign bus.irwrite   = irwrite_s;
    assign bus.adrsrc    = adrsrc_s;
    assign bus.alusrca   = alusrca_s;
    assign bus.alusrcb   = alusrcb_s;
    assign bus.resultsrc = resultsrc_s;
    assign bus.nextpc    = nextpc_s;
    assign bus.regw      = regw_s;
    assign bus.memw      = memw_s;
    assign bus.branch    = branch_s;
    assign bus.aluop     = aluop_s;

    assign state_o = reset ? 4'(state) : 4'd0;

`ifdef MAIN_FSM_PERF_EN
    // An instruction retires on the clock that leaves its final state.
    // UNKNOWN is not a retirement.
    logic retire;
    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                    (state == S_ALUWB) || (state == S_BRANCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_fsm.sv
// ----------------------------------------------------------------------------
// tb_main_fsm
//   Directed testbench for main_fsm. Each instruction class is walked through
//   its expected state sequence; at every step the debug state and the full
//   control vector are compared with values written down from the state
//   output table. op/funct are scrambled in states that must ignore them.
//   With MAIN_FSM_PERF_EN defined the counters are built with CNT_W=4.
// ----------------------------------------------------------------------------
module tb_main_fsm;

    logic clk;
    logic reset;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    main_fsm_if bus ();

`ifdef MAIN_FSM_PERF_EN
    logic [3:0] cycle_cnt;
    logic [3:0] instr_cnt;
    int exp_cycles = 0;
    int exp_instrs = 0;

    main_fsm #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt),
        .state_o   (state_o)
    );
`else
    main_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .state_o (state_o)
    );
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- expected control vectors ----------------
    // {irwrite, adrsrc, alusrca, alusrcb, resultsrc, nextpc, regw, memw, branch, aluop}
    localparam logic [12:0] C_FETCH    = 13'b1_0_01_10_10_1_0_0_0_0;
    localparam logic [12:0] C_DECODE   = 13'b0_0_01_10_10_0_0_0_0_0;
    localparam logic [12:0] C_MEMADR   = 13'b0_0_00_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMREAD  = 13'b0_1_00_00_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMWB    = 13'b0_0_00_00_01_0_1_0_0_0;
    localparam logic [12:0] C_MEMWRITE = 13'b0_1_00_00_00_0_0_1_0_0;
    localparam logic [12:0] C_EXECUTER = 13'b0_0_00_00_00_0_0_0_0_1;
    localparam logic [12:0] C_EXECUTEI = 13'b0_0_00_01_00_0_0_0_0_1;
    localparam logic [12:0] C_ALUWB    = 13'b0_0_00_00_00_0_1_0_0_0;
    localparam logic [12:0] C_BRANCH   = 13'b0_0_00_01_10_0_0_0_1_0;
    localparam logic [12:0] C_ZERO     = 13'b0;
    localparam logic [12:0] C_RESET    = 13'b0_0_01_10_10_0_0_0_0_0;

    function automatic logic [12:0] exp_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return C_FETCH;
            4'd1:    return C_DECODE;
            4'd2:    return C_MEMADR;
            4'd3:    return C_MEMREAD;
            4'd4:    return C_MEMWB;
            4'd5:    return C_MEMWRITE;
            4'd6:    return C_EXECUTER;
            4'd7:    return C_EXECUTEI;
            4'd8:    return C_ALUWB;
            4'd9:    return C_BRANCH;
            default: return C_ZERO;
        endcase
    endfunction

    function automatic logic [12:0] obs_ctrl();
        return {bus.irwrite, bus.adrsrc, bus.alusrca, bus.alusrcb, bus.resultsrc,
                bus.nextpc, bus.regw, bus.memw, bus.branch, bus.aluop};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
`ifdef MAIN_FSM_PERF_EN
        if (reset) exp_cycles++;
`endif
    endtask

    // ---------------- driver ----------------
    // Runs one instruction from FETCH. seq holds n state codes, first code in
    // the most significant used nibble; the last code is the FETCH that
    // follows. Ends positioned in that FETCH.
    task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f,
                             input int n, input logic [23:0] seq);
        logic [3:0] es;
        for (int i = 0; i < n; i++) begin
            es = seq[4*(n-1-i) +: 4];
            check($sformatf("%s state[%0d]", name, i), 32'(state_o), 32'(es));
            check($sformatf("%s ctrl[%0d]", name, i), 32'(obs_ctrl()), 32'(exp_ctrl(es)));
            if (es == 4'd1 || es == 4'd2) begin
                bus.op    = o;
                bus.funct = f;
            end else begin
                bus.op    = 2'($urandom_range(0, 3));
                bus.funct = 6'($urandom_range(0, 63));
            end
            if (i < n - 1) step();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b0;
        bus.op    = 2'b00;
        bus.funct = 6'b0;

        // Two cycles in reset: strobes off, FETCH selects, state_o 0.
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("reset state[%0d]", i), 32'(state_o), 32'd0);
            check($sformatf("reset ctrl[%0d]", i), 32'(obs_ctrl()), 32'(C_RESET));
`ifdef MAIN_FSM_PERF_EN
            check($sformatf("reset cycle_cnt[%0d]", i), 32'(cycle_cnt), 32'd0);
            check($sformatf("reset instr_cnt[%0d]", i), 32'(instr_cnt), 32'd0);
`endif
        end

        // Release: FETCH strobes appear at once, DECODE follows.
        reset = 1'b1;
        #1;
        check("release irwrite", 32'(bus.irwrite), 32'd1);
        check("release nextpc", 32'(bus.nextpc), 32'd1);
        run_instr("LDR", 2'b01, 6'b011001, 6, 24'h012340);
        run_instr("STR", 2'b01, 6'b011000, 5, 24'h001250);
        run_instr("DP_IMM", 2'b00, 6'b101000, 5, 24'h001780);
        run_instr("DP_REG", 2'b00, 6'b001000, 5, 24'h001680);
        run_instr("B", 2'b10, 6'b000000, 4, 24'h000190);
        run_instr("UNDEF", 2'b11, 6'b000000, 4, 24'h0001a0);
        run_instr("LDR2", 2'b01, 6'b111111, 6, 24'h012340);

        // Reset in MEMREAD: outputs gated immediately, FETCH after the edge.
        bus.op    = 2'b01;
        bus.funct = 6'b000001;
        step();
        step();
        step();
        check("midreset pre state", 32'(state_o), 32'd3);
        reset = 1'b0;
        #1;
        check("midreset gated state", 32'(state_o), 32'd0);
        check("midreset gated ctrl", 32'(obs_ctrl()), 32'(C_RESET));
        step();
        check("midreset post ctrl", 32'(obs_ctrl()), 32'(C_RESET));
`ifdef MAIN_FSM_PERF_EN
        check("midreset cycle_cnt", 32'(cycle_cnt), 32'd0);
        check("midreset instr_cnt", 32'(instr_cnt), 32'd0);
        exp_cycles = 0;
`endif
        reset = 1'b1;
        #1;
        check("midreset release state", 32'(state_o), 32'd0);
        check("midreset release ctrl", 32'(obs_ctrl()), 32'(C_FETCH));

`ifdef MAIN_FSM_PERF_EN
        // 20 retiring instructions plus one UNKNOWN that must not count.
        for (int k = 0; k < 20; k++) begin
            case (k % 5)
                0: run_instr("pLDR", 2'b01, 6'b011001, 6, 24'h012340);
                1: run_instr("pSTR", 2'b01, 6'b011000, 5, 24'h001250);
                2: run_instr("pDP_IMM", 2'b00, 6'b101000, 5, 24'h001780);
                3: run_instr("pDP_REG", 2'b00, 6'b001000, 5, 24'h001680);
                default: run_instr("pB", 2'b10, 6'b000000, 4, 24'h000190);
            endcase
            exp_instrs++;
        end
        run_instr("pUNDEF", 2'b11, 6'b000000, 4, 24'h0001a0);
        check("perf instr_cnt", 32'(instr_cnt), 32'(exp_instrs % 16));
        check("perf instr_cnt wrap", 32'(instr_cnt), 32'd4);
        check("perf cycle_cnt", 32'(cycle_cnt), 32'(exp_cycles % 16));

        // Reset again mid-instruction: both counters clear.
        bus.op    = 2'b01;
        bus.funct = 6'b000001;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check("perf reset state", 32'(state_o), 32'd0);
        check("perf reset cycle_cnt", 32'(cycle_cnt), 32'd0);
        check("perf reset instr_cnt", 32'(instr_cnt), 32'd0);
        reset = 1'b1;
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
